// File: rtl/load_value_verifier_pkg.sv
// rtl/load_value_verifier_pkg.sv - shared widths and state encodings for the load value verifier
package load_value_verifier_pkg;

  localparam int LVV_ADDRESS_WIDTH    = 32;
  localparam int LVV_CHECKPOINT_WIDTH = 2;
  localparam int LVV_DATA_WIDTH       = 32;
  localparam int LVV_REG_ADDR_WIDTH   = 5;
  localparam int LVV_FREE_LIST_WIDTH  = 6;
  localparam int LVV_DEPTH            = 4;
  localparam int LVV_RECOVER_CYCLES   = 2;

  typedef enum logic [1:0] {
    LVV_IDLE    = 2'd0,
    LVV_RUN     = 2'd1,
    LVV_RECOVER = 2'd2
  } lvv_state_t;

endpackage

// File: rtl/value_pred_fifo.sv
// rtl/value_pred_fifo.sv - in-order storage for outstanding predicted loads
module value_pred_fifo
  import load_value_verifier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = LVV_DEPTH
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Push,
  input  logic                       i_Pop,
  input  logic                       i_Flush,
  input  logic [WIDTH-1:0]           i_Push_Data,
  output logic [WIDTH-1:0]           o_Head_Data,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Full,
  output logic                       o_Empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign o_Full      = (o_Count == (PW+1)'(DEPTH));
  assign o_Empty     = (o_Count == '0);
  assign push_ok     = i_Push && !o_Full;
  assign pop_ok      = i_Pop && !o_Empty;
  assign o_Head_Data = mem[rd_ptr];

  // Entry storage has no reset; validity is tracked by the count.
  always_ff @(posedge i_Clk) begin
    if (push_ok) mem[wr_ptr] <= i_Push_Data;
  end

  // Pointers wrap modulo DEPTH; a flush discards everything including a same-cycle push.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   o_Count <= o_Count + 1'b1;
        2'b01:   o_Count <= o_Count - 1'b1;
        default: o_Count <= o_Count;
      endcase
    end
  end

endmodule

// File: rtl/load_value_verifier.sv
// rtl/load_value_verifier.sv - checks load completions against predictions and requests recovery
module load_value_verifier
  import load_value_verifier_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = LVV_ADDRESS_WIDTH,
  parameter int CHECKPOINT_WIDTH = LVV_CHECKPOINT_WIDTH,
  parameter int DATA_WIDTH       = LVV_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH   = LVV_REG_ADDR_WIDTH,
  parameter int FREE_LIST_WIDTH  = LVV_FREE_LIST_WIDTH,
  parameter int DEPTH            = LVV_DEPTH,
  parameter int RECOVER_CYCLES   = LVV_RECOVER_CYCLES
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Issue_Valid,
  input  logic [ADDRESS_WIDTH-1:0]    i_Issue_PC,
  input  logic [CHECKPOINT_WIDTH-1:0] i_Issue_Checkpoint,
  input  logic [DATA_WIDTH-1:0]       i_Issue_Predicted_Data,
  input  logic [REG_ADDR_WIDTH:0]     i_Issue_PWrite_Addr,
  input  logic [FREE_LIST_WIDTH-1:0]  i_Issue_Active_List_Index,
  output logic                        o_Issue_Ready,
  input  logic                        i_Mem_Done,
  input  logic [DATA_WIDTH-1:0]       i_Mem_Data,
  output logic                        o_Verify_Valid,
  output logic                        o_Verify_Correct,
  output logic [DATA_WIDTH-1:0]       o_Verify_Data,
  output logic [REG_ADDR_WIDTH:0]     o_Verify_PWrite_Addr,
  output logic [FREE_LIST_WIDTH-1:0]  o_Verify_Active_List_Index,
  output logic                        o_Recover,
  output logic [ADDRESS_WIDTH-1:0]    o_Recover_PC,
  output logic [CHECKPOINT_WIDTH-1:0] o_Recover_Checkpoint,
  output logic [$clog2(DEPTH):0]      o_Outstanding,
  output logic                        o_Underflow
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);
  localparam int EW  = ADDRESS_WIDTH + CHECKPOINT_WIDTH + DATA_WIDTH
                     + REG_ADDR_WIDTH + 1 + FREE_LIST_WIDTH;

  lvv_state_t state;
  logic [RCW-1:0] rec_cnt;

  logic [EW-1:0]               head_entry;
  logic [ADDRESS_WIDTH-1:0]    head_pc;
  logic [CHECKPOINT_WIDTH-1:0] head_ckpt;
  logic [DATA_WIDTH-1:0]       head_pred;
  logic [REG_ADDR_WIDTH:0]     head_paddr;
  logic [FREE_LIST_WIDTH-1:0]  head_ali;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        issue_fire;
  logic                        done_fire;
  logic                        mispredict;
  logic                        pop_ok;
  logic [CW-1:0]               next_count;

  assign {head_pc, head_ckpt, head_pred, head_paddr, head_ali} = head_entry;

  // Ready uses pre-pop occupancy, so a full FIFO never takes an issue even when it pops.
  assign o_Issue_Ready = !fifo_full && (state != LVV_RECOVER);
  assign issue_fire    = i_Issue_Valid && o_Issue_Ready;
  assign done_fire     = i_Mem_Done && !fifo_empty && (state != LVV_RECOVER);
  assign mispredict    = done_fire && (head_pred != i_Mem_Data);
  assign pop_ok        = done_fire && !mispredict;
  assign next_count    = o_Outstanding + CW'(issue_fire) - CW'(pop_ok);

  value_pred_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Push      (issue_fire),
    .i_Pop       (pop_ok),
    .i_Flush     (mispredict),
    .i_Push_Data ({i_Issue_PC, i_Issue_Checkpoint, i_Issue_Predicted_Data,
                   i_Issue_PWrite_Addr, i_Issue_Active_List_Index}),
    .o_Head_Data (head_entry),
    .o_Count     (o_Outstanding),
    .o_Full      (fifo_full),
    .o_Empty     (fifo_empty)
  );

  // Control FSM with registered verify, recover and underflow outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state                      <= LVV_IDLE;
      rec_cnt                    <= '0;
      o_Verify_Valid             <= 1'b0;
      o_Verify_Correct           <= 1'b0;
      o_Verify_Data              <= '0;
      o_Verify_PWrite_Addr       <= '0;
      o_Verify_Active_List_Index <= '0;
      o_Recover                  <= 1'b0;
      o_Recover_PC               <= '0;
      o_Recover_Checkpoint       <= '0;
      o_Underflow                <= 1'b0;
    end else begin
      o_Verify_Valid <= done_fire;
      if (done_fire) begin
        o_Verify_Correct           <= !mispredict;
        o_Verify_Data              <= i_Mem_Data;
        o_Verify_PWrite_Addr       <= head_paddr;
        o_Verify_Active_List_Index <= head_ali;
      end
      if (i_Mem_Done && fifo_empty && (state != LVV_RECOVER)) o_Underflow <= 1'b1;

      case (state)
        LVV_RECOVER: begin
          if (rec_cnt == RCW'(1)) begin
            o_Recover <= 1'b0;
            rec_cnt   <= '0;
            state     <= LVV_IDLE;
          end else begin
            rec_cnt <= rec_cnt - 1'b1;
          end
        end
        default: begin
          if (mispredict) begin
            o_Recover            <= 1'b1;
            o_Recover_PC         <= head_pc;
            o_Recover_Checkpoint <= head_ckpt;
            rec_cnt              <= RCW'(RECOVER_CYCLES);
            state                <= LVV_RECOVER;
          end else begin
            state <= (next_count == '0) ? LVV_IDLE : LVV_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_value_verifier.sv
// tb/tb_load_value_verifier.sv - directed self-checking bench for load_value_verifier
module tb_load_value_verifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_v;
  logic [31:0] iss_pc;
  logic [1:0]  iss_ck;
  logic [31:0] iss_pd;
  logic [5:0]  iss_pa;
  logic [5:0]  iss_ali;
  logic        iss_rdy;
  logic        done;
  logic [31:0] mdata;
  logic        v_valid;
  logic        v_corr;
  logic [31:0] v_data;
  logic [5:0]  v_pa;
  logic [5:0]  v_ali;
  logic        rec;
  logic [31:0] rec_pc;
  logic [1:0]  rec_ck;
  logic [2:0]  outst;
  logic        uflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_value_verifier dut (
    .i_Clk                      (clk),
    .i_Reset                    (rst),
    .i_Issue_Valid              (iss_v),
    .i_Issue_PC                 (iss_pc),
    .i_Issue_Checkpoint         (iss_ck),
    .i_Issue_Predicted_Data     (iss_pd),
    .i_Issue_PWrite_Addr        (iss_pa),
    .i_Issue_Active_List_Index  (iss_ali),
    .o_Issue_Ready              (iss_rdy),
    .i_Mem_Done                 (done),
    .i_Mem_Data                 (mdata),
    .o_Verify_Valid             (v_valid),
    .o_Verify_Correct           (v_corr),
    .o_Verify_Data              (v_data),
    .o_Verify_PWrite_Addr       (v_pa),
    .o_Verify_Active_List_Index (v_ali),
    .o_Recover                  (rec),
    .o_Recover_PC               (rec_pc),
    .o_Recover_Checkpoint       (rec_ck),
    .o_Outstanding              (outst),
    .o_Underflow                (uflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [31:0] pc, input logic [1:0] ck,
                           input logic [31:0] pd, input logic [5:0] ali);
    iss_v   = 1'b1;
    iss_pc  = pc;
    iss_ck  = ck;
    iss_pd  = pd;
    iss_pa  = ali + 6'd1;
    iss_ali = ali;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [1:0] ck,
                       input logic [31:0] pd, input logic [5:0] ali);
    set_issue(pc, ck, pd, ali);
    tick();
    iss_v = 1'b0;
  endtask

  task automatic complete(input logic [31:0] d);
    done  = 1'b1;
    mdata = d;
    tick();
    done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iss_v = 1'b0; iss_pc = '0; iss_ck = '0; iss_pd = '0;
    iss_pa = '0; iss_ali = '0; done = 1'b0; mdata = '0;
    tick(); tick();
    chk("rst_verify_valid", v_valid, 0);
    chk("rst_recover", rec, 0);
    chk("rst_outstanding", outst, 0);
    chk("rst_underflow", uflow, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", iss_rdy, 1);

    // 1: correct prediction
    issue(32'h100, 2'd0, 32'hA5, 6'd1);
    chk("t1_outstanding_1", outst, 1);
    complete(32'hA5);
    chk("t1_valid", v_valid, 1);
    chk("t1_correct", v_corr, 1);
    chk("t1_data", v_data, 32'hA5);
    chk("t1_ali", v_ali, 1);
    chk("t1_paddr", v_pa, 2);
    chk("t1_recover", rec, 0);
    chk("t1_outstanding_0", outst, 0);
    tick();
    chk("t1_valid_pulse", v_valid, 0);

    // 2: mispredict and recovery window
    issue(32'h200, 2'd2, 32'h10, 6'd5);
    complete(32'h11);
    chk("t2_valid", v_valid, 1);
    chk("t2_correct", v_corr, 0);
    chk("t2_data", v_data, 32'h11);
    chk("t2_recover_c1", rec, 1);
    chk("t2_rec_pc", rec_pc, 32'h200);
    chk("t2_rec_ck", rec_ck, 2);
    chk("t2_ready_c1", iss_rdy, 0);
    issue(32'h999, 2'd3, 32'h77, 6'd9);
    chk("t2_recover_c2", rec, 1);
    chk("t2_ready_c2", iss_rdy, 0);
    chk("t2_rec_pc_held", rec_pc, 32'h200);
    chk("t2_drop_in_recover", outst, 0);
    tick();
    chk("t2_recover_end", rec, 0);
    chk("t2_ready_after", iss_rdy, 1);

    // 3: fill to DEPTH, drop 5th, drain in order
    for (int i = 0; i < 4; i++) issue(32'h400 + i * 4, 2'(i), 32'h1000 + i, 6'(10 + i));
    chk("t3_outstanding_full", outst, 4);
    chk("t3_ready_full", iss_rdy, 0);
    issue(32'h410, 2'd0, 32'h2000, 6'd14);
    chk("t3_fifth_dropped", outst, 4);
    for (int i = 0; i < 4; i++) begin
      complete(32'h1000 + i);
      chk("t3_order_ali", v_ali, 10 + i);
      chk("t3_correct", v_corr, 1);
    end
    chk("t3_drained", outst, 0);

    // 4: second of three mispredicts, third squashed, dones during recover ignored
    for (int i = 0; i < 3; i++) issue(32'h300 + i * 4, 2'(i), 32'h20 + i, 6'(20 + i));
    complete(32'h20);
    chk("t4_first_ok", v_corr, 1);
    complete(32'h99);
    chk("t4_mispredict", v_corr, 0);
    chk("t4_ali", v_ali, 21);
    chk("t4_rec_pc", rec_pc, 32'h304);
    chk("t4_rec_ck", rec_ck, 1);
    chk("t4_flushed", outst, 0);
    done = 1'b1; mdata = 32'h22;
    tick();
    chk("t4_done_ignored", v_valid, 0);
    chk("t4_recover_c2", rec, 1);
    tick();
    done = 1'b0;
    chk("t4_recover_end", rec, 0);
    chk("t4_no_underflow", uflow, 0);
    chk("t4_still_empty", outst, 0);

    // 5: simultaneous issue and done with 2 outstanding
    issue(32'h500, 2'd0, 32'h30, 6'd30);
    issue(32'h504, 2'd1, 32'h31, 6'd31);
    set_issue(32'h508, 2'd2, 32'h32, 6'd32);
    complete(32'h30);
    iss_v = 1'b0;
    chk("t5_count_same", outst, 2);
    chk("t5_ali0", v_ali, 30);
    complete(32'h31);
    chk("t5_ali1", v_ali, 31);
    complete(32'h32);
    chk("t5_ali2", v_ali, 32);
    chk("t5_correct2", v_corr, 1);
    chk("t5_empty", outst, 0);

    // 6: underflow sticky, reset mid-recover
    complete(32'h0);
    chk("t6_underflow", uflow, 1);
    chk("t6_no_verify", v_valid, 0);
    tick();
    chk("t6_underflow_sticky", uflow, 1);
    issue(32'h600, 2'd3, 32'h40, 6'd40);
    complete(32'h41);
    chk("t6_recover_on", rec, 1);
    rst = 1'b1;
    tick();
    chk("t6_reset_recover", rec, 0);
    chk("t6_reset_underflow", uflow, 0);
    chk("t6_reset_outstanding", outst, 0);
    rst = 1'b0;
    tick();
    chk("t6_ready_after_reset", iss_rdy, 1);
    chk("t6_recover_stays_0", rec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
